// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled deserialiser with even-parity and stop-bit checking.
// Frame format is latched at the start bit; a framing error locks out reception until the line idles.
module uart_rx #(
  parameter int unsigned NUM_TICKS     = 16,
  parameter int unsigned BITS_PER_DATA = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic                     rx_in,
  input  logic                     parity,
  input  logic [1:0]               stop_bits,
  output logic [BITS_PER_DATA-1:0] d_out,
  output logic                     rx_done,
  output logic                     parity_err,
  output logic                     frame_err
);

  localparam int unsigned SW = $clog2(NUM_TICKS);
  localparam int unsigned NW = (BITS_PER_DATA > 1) ? $clog2(BITS_PER_DATA) : 1;
  localparam logic [SW-1:0] SMid  = SW'(NUM_TICKS / 2 - 1);
  localparam logic [SW-1:0] SLast = SW'(NUM_TICKS - 1);
  localparam logic [NW-1:0] NLast = NW'(BITS_PER_DATA - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                   state_q, state_d;
  logic [SW-1:0]            s_q, s_d;
  logic [NW-1:0]            n_q, n_d;
  logic [BITS_PER_DATA-1:0] shift_q, shift_d;
  logic                     pbit_q, pbit_d;
  logic                     ferr_q, ferr_d;
  logic                     brk_q, brk_d;
  logic                     par_q, par_d;
  logic [1:0]               stop_q, stop_d;
  logic [1:0]               scnt_q, scnt_d;
  logic [BITS_PER_DATA-1:0] d_out_q, d_out_d;
  logic                     rx_done_q, rx_done_d;
  logic                     perr_q, perr_d;
  logic                     frerr_q, frerr_d;
  logic                     rx_meta_q, rx_s_q;
  logic [1:0]               stop_need;
  logic                     ferr_now;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    shift_d   = shift_q;
    pbit_d    = pbit_q;
    ferr_d    = ferr_q;
    brk_d     = brk_q;
    par_d     = par_q;
    stop_d    = stop_q;
    scnt_d    = scnt_q;
    d_out_d   = d_out_q;
    rx_done_d = 1'b0;
    perr_d    = perr_q;
    frerr_d   = frerr_q;
    stop_need = (stop_q == 2'd0) ? 2'd1 : stop_q;
    ferr_now  = ferr_q | ~rx_s_q;

    if (tick) begin
      case (state_q)
        StIdle: begin
          if (rx_s_q) begin
            brk_d = 1'b0;
          end else if (!brk_q) begin
            state_d = StStart;
            s_d     = '0;
            par_d   = parity;
            stop_d  = stop_bits;
          end
        end
        StStart: begin
          if (s_q == SMid) begin
            if (!rx_s_q) begin
              state_d = StData;
              s_d     = '0;
              n_d     = '0;
              ferr_d  = 1'b0;
              scnt_d  = 2'd0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
        StData: begin
          if (s_q == SLast) begin
            s_d     = '0;
            shift_d = {rx_s_q, shift_q[BITS_PER_DATA-1:1]};
            if (n_q == NLast) begin
              state_d = par_q ? StParity : StStop;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
        StParity: begin
          if (s_q == SLast) begin
            s_d     = '0;
            pbit_d  = rx_s_q;
            state_d = StStop;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
        StStop: begin
          if (s_q == SLast) begin
            s_d    = '0;
            ferr_d = ferr_now;
            if (scnt_q == stop_need - 2'd1) begin
              // Final stop sample: publish the frame and arm break-lock on a framing error.
              state_d   = StIdle;
              d_out_d   = shift_q;
              perr_d    = par_q & ((^shift_q) ^ pbit_q);
              frerr_d   = ferr_now;
              rx_done_d = 1'b1;
              brk_d     = ferr_now;
            end else begin
              scnt_d = scnt_q + 2'd1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      s_q       <= '0;
      n_q       <= '0;
      shift_q   <= '0;
      pbit_q    <= 1'b0;
      ferr_q    <= 1'b0;
      brk_q     <= 1'b0;
      par_q     <= 1'b0;
      stop_q    <= 2'd0;
      scnt_q    <= 2'd0;
      d_out_q   <= '0;
      rx_done_q <= 1'b0;
      perr_q    <= 1'b0;
      frerr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      shift_q   <= shift_d;
      pbit_q    <= pbit_d;
      ferr_q    <= ferr_d;
      brk_q     <= brk_d;
      par_q     <= par_d;
      stop_q    <= stop_d;
      scnt_q    <= scnt_d;
      d_out_q   <= d_out_d;
      rx_done_q <= rx_done_d;
      perr_q    <= perr_d;
      frerr_q   <= frerr_d;
    end
  end

  assign d_out      = d_out_q;
  assign rx_done    = rx_done_q;
  assign parity_err = perr_q;
  assign frame_err  = frerr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised and directed bench for uart_rx; a frame-level model predicts the tick of every
// rx_done and the persistent output values, and a compare process checks them each clock.
module tb_uart_rx;

  localparam int P  = 4;   // clocks per tick slot; the tick pulse is the last clock of a slot
  localparam int NT = 16;  // ticks per bit

  logic       clk, reset, tick, rx_in, parity;
  logic [1:0] stop_bits;
  logic [7:0] d_out;
  logic       rx_done, parity_err, frame_err;

  uart_rx #(.NUM_TICKS(NT), .BITS_PER_DATA(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .rx_in     (rx_in),
    .parity    (parity),
    .stop_bits (stop_bits),
    .d_out     (d_out),
    .rx_done   (rx_done),
    .parity_err(parity_err),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         slot_n = 0;
  int         cmp_tick = 0;
  int         done_cnt = 0;
  int         last_done_tick = 0;
  int         prev_done_tick = 0;
  logic [7:0] exp_d = '0;
  logic       exp_pe = 1'b0;
  logic       exp_fe = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One tick slot: line value held for P clocks, tick pulsed in the last one.
  task automatic slot(input logic v);
    rx_in = v;
    repeat (P - 1) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    slot_n++;
  endtask

  task automatic bit_time(input logic v);
    repeat (NT) slot(v);
  endtask

  // Frame of 1 start + 8 data + optional parity + stop bits; bit k is sampled NT*k + NT/2 ticks
  // after the first low tick, so the final stop sample fixes the rx_done tick.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb,
                            input logic [1:0] sb, input logic [2:0] sv, input bit scramble);
    int   ns;
    int   total;
    exp_t e;
    ns    = (sb == 2'd0) ? 1 : int'(sb);
    total = 1 + 8 + int'(pe) + ns;
    e.t   = slot_n + NT * (total - 1) + NT / 2;
    e.d   = d;
    e.pe  = pe & ((^d) ^ pb);
    e.fe  = 1'b0;
    for (int k = 0; k < ns; k++) if (!sv[k]) e.fe = 1'b1;
    q.push_back(e);
    parity    = pe;
    stop_bits = sb;
    bit_time(1'b0);
    if (scramble) begin
      parity    = 1'($urandom_range(0, 1));
      stop_bits = 2'($urandom_range(0, 3));
    end
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    if (pe) bit_time(pb);
    for (int k = 0; k < ns; k++) bit_time(sv[k]);
  endtask

  always @(posedge clk) begin
    int idx;
    bit want;
    #1;
    idx = cmp_tick;
    if (tick) cmp_tick++;
    if (!reset) begin
      q.delete();
      exp_d  = '0;
      exp_pe = 1'b0;
      exp_fe = 1'b0;
      check("reset_outputs", {rx_done, parity_err, frame_err, d_out}, 0);
    end else begin
      want = tick && (q.size() > 0) && (q[0].t == idx);
      check("rx_done", rx_done, want);
      if (want) begin
        exp_d  = q[0].d;
        exp_pe = q[0].pe;
        exp_fe = q[0].fe;
        void'(q.pop_front());
      end
      if (rx_done) begin
        done_cnt++;
        prev_done_tick = last_done_tick;
        last_done_tick = idx;
      end
      check("d_out", d_out, exp_d);
      check("parity_err", parity_err, exp_pe);
      check("frame_err", frame_err, exp_fe);
    end
  end

  initial begin
    int         base;
    logic [7:0] rd;
    logic       rpe, rpb;
    logic [1:0] rsb;
    logic [2:0] rsv;
    int         rns, rgap;

    reset = 1'b0; tick = 1'b0; rx_in = 1'b1; parity = 1'b0; stop_bits = 2'd1;
    repeat (3) @(negedge clk);
    check("por_dout", d_out, 0);
    check("por_done", rx_done, 0);
    reset = 1'b1;
    repeat (20) slot(1'b1);

    base = done_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, 2'd1, 3'b111, 1'b0);
    repeat (NT) slot(1'b1);
    check("a5_dout", d_out, 8'hA5);
    check("a5_errs", {parity_err, frame_err}, 2'b00);
    check("a5_count", done_cnt - base, 1);

    send_frame(8'h07, 1'b1, 1'b1, 2'd2, 3'b111, 1'b0);
    check("p07_ok_dout", d_out, 8'h07);
    check("p07_ok_errs", {parity_err, frame_err}, 2'b00);
    send_frame(8'h07, 1'b1, 1'b0, 2'd2, 3'b111, 1'b0);
    check("p07_bad_perr", parity_err, 1);
    check("p07_bad_dout", d_out, 8'h07);

    send_frame(8'h3C, 1'b0, 1'b0, 2'd1, 3'b000, 1'b0);
    check("brk_ferr", frame_err, 1);
    check("brk_dout", d_out, 8'h3C);
    base = done_cnt;
    repeat (30 * NT) slot(1'b0);
    bit_time(1'b1);
    check("brk_silent", done_cnt - base, 0);
    send_frame(8'h55, 1'b0, 1'b0, 2'd1, 3'b111, 1'b0);
    check("brk_resume_dout", d_out, 8'h55);
    check("brk_resume_ferr", frame_err, 0);
    repeat (NT) slot(1'b1);

    base = done_cnt;
    repeat (4) slot(1'b0);
    bit_time(1'b1);
    check("glitch_silent", done_cnt - base, 0);
    send_frame(8'h81, 1'b0, 1'b0, 2'd0, 3'b111, 1'b0);
    check("glitch_next_dout", d_out, 8'h81);
    repeat (NT) slot(1'b1);

    // Reset in the middle of data bit 3 of 0xFF; no expectation is queued for it.
    parity = 1'b0; stop_bits = 2'd1;
    bit_time(1'b0);
    repeat (3) bit_time(1'b1);
    repeat (NT / 2) slot(1'b1);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_outs", {rx_done, parity_err, frame_err, d_out}, 0);
    reset = 1'b1;
    bit_time(1'b1);
    send_frame(8'h3C, 1'b0, 1'b0, 2'd1, 3'b111, 1'b0);
    check("midrst_next_dout", d_out, 8'h3C);
    repeat (NT) slot(1'b1);

    base = done_cnt;
    send_frame(8'h12, 1'b0, 1'b0, 2'd1, 3'b111, 1'b0);
    check("b2b_first", d_out, 8'h12);
    send_frame(8'h34, 1'b0, 1'b0, 2'd1, 3'b111, 1'b0);
    check("b2b_second", d_out, 8'h34);
    check("b2b_spacing", last_done_tick - prev_done_tick, 10 * NT);
    check("b2b_count", done_cnt - base, 2);
    repeat (NT) slot(1'b1);

    for (int f = 0; f < 25; f++) begin
      rd   = 8'($urandom);
      rpe  = 1'($urandom_range(0, 1));
      rsb  = 2'($urandom_range(0, 3));
      rns  = (rsb == 2'd0) ? 1 : int'(rsb);
      rpb  = (^rd) ^ ($urandom_range(0, 3) == 0);
      rsv  = 3'b111;
      if ($urandom_range(0, 3) == 0) rsv[$urandom_range(0, rns - 1)] = 1'b0;
      send_frame(rd, rpe, rpb, rsb, rsv, 1'b1);
      rgap = $urandom_range(0, 20);
      // An errored frame arms break-lock, so the line must idle high for a tick to resume.
      if (rsv != 3'b111 && rgap == 0) rgap = 1;
      repeat (rgap) slot(1'b1);
    end

    repeat (40) slot(1'b1);
    check("all_frames_seen", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
